// File: rtl/prog_loader.sv
// Loads a 16-bit program from a byte stream into local RAM, then serves mem[pc] to the core.
// Latency: RAM write on the HI-byte edge, fetch is combinational; run rises the edge after the last byte.
// Backpressure: in_ready is low in RUN and during reset; bytes move only on in_valid && in_ready.
module prog_loader #(
    parameter int          PC_W     = 8,
    parameter int          ADDR_W   = 6,
    parameter logic [15:0] NOP_INSN = 16'h8000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PC_W-1:0]   pc,
    output logic [15:0]       instruction,
    output logic              run,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              load_req,
    output logic              overflow,
    output logic [ADDR_W:0]   loaded_cnt
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    localparam logic [1:0] ST_HDR = 2'd0;
    localparam logic [1:0] ST_LO  = 2'd1;
    localparam logic [1:0] ST_HI  = 2'd2;
    localparam logic [1:0] ST_RUN = 2'd3;

    logic [1:0]  state;
    logic [7:0]  remaining;
    logic [7:0]  addr;
    logic [7:0]  lo_byte;
    logic [15:0] mem [DEPTH];

    logic take;
    logic addr_ok;
    logic wr_en;

    assign in_ready = rst_n && (state != ST_RUN);
    assign take     = in_valid && in_ready;
    // addr tracks the full header count so words past DEPTH are detected, not wrapped
    assign addr_ok  = 32'(addr) < DEPTH;
    assign wr_en    = take && (state == ST_HI) && addr_ok;

    assign run         = (state == ST_RUN);
    assign instruction = run ? mem[pc[ADDR_W-1:0]] : NOP_INSN;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr[ADDR_W-1:0]] <= {in_data, lo_byte};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_HDR;
            remaining  <= '0;
            addr       <= '0;
            lo_byte    <= '0;
            loaded_cnt <= '0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                ST_HDR: begin
                    if (take) begin
                        if (in_data == 8'd0) begin
                            state <= ST_RUN;
                        end else begin
                            remaining  <= in_data;
                            addr       <= '0;
                            loaded_cnt <= '0;
                            overflow   <= 1'b0;
                            state      <= ST_LO;
                        end
                    end
                end
                ST_LO: begin
                    if (take) begin
                        lo_byte <= in_data;
                        state   <= ST_HI;
                    end
                end
                ST_HI: begin
                    if (take) begin
                        if (!addr_ok) begin
                            overflow <= 1'b1;
                        end
                        if (loaded_cnt != FULL_CNT) begin
                            loaded_cnt <= loaded_cnt + 1'b1;
                        end
                        addr      <= addr + 8'd1;
                        remaining <= remaining - 8'd1;
                        state     <= (remaining == 8'd1) ? ST_RUN : ST_LO;
                    end
                end
                default: begin
                    if (load_req) begin
                        state <= ST_HDR;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: randomized byte timing, reference RAM model, decoupled fetch monitor.
module tb_prog_loader;
    typedef logic [15:0] wq_t[$];
    typedef struct {
        logic [15:0] insn;
        logic [6:0]  cnt;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  pc;
    logic [15:0] instruction;
    logic        run;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        load_req;
    logic        overflow;
    logic [6:0]  loaded_cnt;

    int total = 0;
    int bad   = 0;

    logic [15:0] ref_mem [64];
    int          ref_cnt = 0;
    bit          ref_ovf = 0;
    exp_t        sbq[$];
    exp_t        mon_e;
    logic        chk_en = 1'b0;

    always #5 clk = ~clk;

    prog_loader dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .instruction(instruction), .run(run),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .load_req(load_req), .overflow(overflow), .loaded_cnt(loaded_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: whenever a fetch probe is presented, pop the expected response and compare.
    always @(negedge clk) begin
        if (chk_en) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL fetch: got instruction %0h with empty scoreboard", instruction);
            end else begin
                mon_e = sbq.pop_front();
                check("fetch_run", {31'd0, run}, 32'd1);
                check("fetch_insn", {16'd0, instruction}, {16'd0, mon_e.insn});
                check("fetch_cnt", {25'd0, loaded_cnt}, {25'd0, mon_e.cnt});
                check("fetch_ovf", {31'd0, overflow}, {31'd0, mon_e.ovf});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit pulse_req, output bit ok, output bit run_before);
        bit r;
        ok = 0;
        run_before = 0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = b;
            load_req = pulse_req && (t == 0);
            #1;
            r = in_ready;
            run_before = run;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            load_req = 1'b0;
            if (r) begin
                ok = 1;
                break;
            end
        end
        check("byte_accept", {31'd0, ok}, 32'd1);
    endtask

    task automatic load_prog(input wq_t w, input int req_at);
        bit ok, rb;
        int n = w.size();
        send_byte(8'(n), req_at == 0, ok, rb);
        for (int i = 0; i < n; i++) begin
            send_byte(w[i][7:0], req_at == 2 * i + 1, ok, rb);
            send_byte(w[i][15:8], req_at == 2 * i + 2, ok, rb);
            if (i < 64) ref_mem[i] = w[i];
        end
        check("run_before_last", {31'd0, rb}, 32'd0);
        check("run_entry", {31'd0, run}, 32'd1);
        check("ready_in_run", {31'd0, in_ready}, 32'd0);
        if (n > 0) begin
            ref_cnt = (n > 64) ? 64 : n;
            ref_ovf = (n > 64);
        end
    endtask

    task automatic probe(input logic [7:0] p);
        exp_t e;
        e.insn = ref_mem[p[5:0]];
        e.cnt  = 7'(ref_cnt);
        e.ovf  = ref_ovf;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        pc = p;
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1'b0;
    endtask

    task automatic leave_run();
        @(negedge clk);
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
        check("req_run", {31'd0, run}, 32'd0);
        check("req_nop", {16'd0, instruction}, 32'h8000);
        check("req_ready", {31'd0, in_ready}, 32'd1);
    endtask

    function automatic wq_t rand_words(input int n);
        wq_t q;
        for (int i = 0; i < n; i++) q.push_back(16'($urandom));
        return q;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        wq_t w;
        bit ok, rb;
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; load_req = 1'b0; pc = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_run", {31'd0, run}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_cnt", {25'd0, loaded_cnt}, 32'd0);
        check("rst_nop", {16'd0, instruction}, 32'h8000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("hdr_ready", {31'd0, in_ready}, 32'd1);

        // Basic two-word program
        w = '{16'h1234, 16'hABCD};
        load_prog(w, -1);
        probe(8'h01);
        probe(8'h00);

        // Same program again with different random byte gaps, load_req pulsed while in LO
        leave_run();
        load_prog(w, 1);
        probe(8'h01);
        probe(8'h00);

        // Oversized program: only the first 64 words land, later words must not wrap
        leave_run();
        w = rand_words(70);
        load_prog(w, -1);
        probe(8'h00);
        probe(8'h3F);
        probe(8'hC0);
        probe(8'h45);

        // Ten-word program, high pc bits ignored, then an empty reload
        leave_run();
        w = rand_words(10);
        load_prog(w, -1);
        probe(8'h45);
        for (int i = 0; i < 6; i++) probe(8'($urandom));
        leave_run();
        w = {};
        load_prog(w, -1);
        probe(8'h45);
        probe(8'h09);

        // Reset after three bytes, then a clean reload
        leave_run();
        send_byte(8'h02, 0, ok, rb);
        send_byte(8'h34, 0, ok, rb);
        send_byte(8'h12, 0, ok, rb);
        ref_mem[0] = 16'h1234;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_run", {31'd0, run}, 32'd0);
        check("midrst_ovf", {31'd0, overflow}, 32'd0);
        check("midrst_cnt", {25'd0, loaded_cnt}, 32'd0);
        check("midrst_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ref_cnt = 0;
        ref_ovf = 0;
        w = '{16'h5A5A, 16'hC3E1};
        load_prog(w, -1);
        probe(8'h00);
        probe(8'h01);
        probe(8'h05);

        repeat (3) @(posedge clk);
        check("sb_drained", sbq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
